// File: rtl/mem_host_arb.sv
// Round-robin arbiter sharing the controller host command port between two masters.
// One command in flight; reads are guarded by a timeout, writes complete after a fixed gap.
module mem_host_arb #(
  parameter int WR_GAP     = 4,
  parameter int RD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req_vld,
  input  logic        r0_req_rdnwr,
  input  logic [15:0] r0_req_addr,
  input  logic [31:0] r0_req_wdata,
  input  logic        r1_req_vld,
  input  logic        r1_req_rdnwr,
  input  logic [15:0] r1_req_addr,
  input  logic [31:0] r1_req_wdata,
  output logic        r0_req_ack,
  output logic        r1_req_ack,
  output logic        r0_rsp_vld,
  output logic        r1_rsp_vld,
  output logic        r0_rsp_err,
  output logic        r1_rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        cmd_n,
  output logic        RDnWR,
  output logic [15:0] Addr_in,
  output logic        Data_in_vld,
  output logic [31:0] Data_in,
  input  logic [31:0] Data_out,
  input  logic        data_out_vld
);

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int CNT_MAX = (RD_TIMEOUT > WR_GAP) ? RD_TIMEOUT : WR_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_GAP - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                sel_q;
  logic                last_grant_q;
  logic                rdnwr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                any_req;
  logic                win1;
  logic                rd_done;
  logic                rd_tmo;
  logic                wr_done;
  logic                done;

  assign any_req = r0_req_vld | r1_req_vld;
  // r1 wins when alone, or when both request and r0 was granted last.
  assign win1    = r1_req_vld & (~r0_req_vld | ~last_grant_q);
  assign rd_done = (state == WAIT_RD) & data_out_vld;
  assign rd_tmo  = (state == WAIT_RD) & ~data_out_vld & (cnt_q == RD_LAST);
  assign wr_done = (state == WAIT_WR) & (cnt_q == WR_LAST);
  assign done    = rd_done | rd_tmo | wr_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = rdnwr_q ? WAIT_RD : WAIT_WR;
      WAIT_RD: if (rd_done || rd_tmo) state_nxt = IDLE;
      WAIT_WR: if (wr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_n       = 1'b1;
    r0_req_ack  = 1'b0;
    r1_req_ack  = 1'b0;
    Data_in_vld = 1'b0;
    if (state == ISSUE) begin
      cmd_n       = 1'b0;
      r0_req_ack  = ~sel_q;
      r1_req_ack  = sel_q;
      Data_in_vld = ~rdnwr_q;
    end
  end

  assign RDnWR   = rdnwr_q;
  assign Addr_in = addr_q;
  assign Data_in = wdata_q;

  // Captured command, grant history, wait counter and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rdnwr_q      <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      r0_rsp_vld   <= 1'b0;
      r1_rsp_vld   <= 1'b0;
      r0_rsp_err   <= 1'b0;
      r1_rsp_err   <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        sel_q   <= win1;
        rdnwr_q <= win1 ? r1_req_rdnwr : r0_req_rdnwr;
        addr_q  <= win1 ? r1_req_addr  : r0_req_addr;
        wdata_q <= win1 ? r1_req_wdata : r0_req_wdata;
      end
      if (state == ISSUE) last_grant_q <= sel_q;
      if (state == WAIT_RD || state == WAIT_WR) cnt_q <= cnt_q + CNT_W'(1);
      else                                      cnt_q <= '0;
      r0_rsp_vld <= done & ~sel_q;
      r1_rsp_vld <= done & sel_q;
      r0_rsp_err <= rd_tmo & ~sel_q;
      r1_rsp_err <= rd_tmo & sel_q;
      if (rd_done)     rsp_rdata <= Data_out;
      else if (rd_tmo) rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_host_arb.sv
// Scoreboard bench for mem_host_arb: directed requests push expected commands and
// responses; negedge monitors pop and compare whenever the DUT strobes.
module tb_mem_host_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req_vld, r1_req_vld;
  logic        r0_req_rdnwr, r1_req_rdnwr;
  logic [15:0] r0_req_addr, r1_req_addr;
  logic [31:0] r0_req_wdata, r1_req_wdata;
  logic        r0_req_ack, r1_req_ack;
  logic        r0_rsp_vld, r1_rsp_vld;
  logic        r0_rsp_err, r1_rsp_err;
  logic [31:0] rsp_rdata;
  logic        cmd_n, RDnWR, Data_in_vld;
  logic [15:0] Addr_in;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  logic        data_out_vld;

  mem_host_arb #(.WR_GAP(4), .RD_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .r0_req_vld(r0_req_vld), .r0_req_rdnwr(r0_req_rdnwr),
    .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata),
    .r1_req_vld(r1_req_vld), .r1_req_rdnwr(r1_req_rdnwr),
    .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata),
    .r0_req_ack(r0_req_ack), .r1_req_ack(r1_req_ack),
    .r0_rsp_vld(r0_rsp_vld), .r1_rsp_vld(r1_rsp_vld),
    .r0_rsp_err(r0_rsp_err), .r1_rsp_err(r1_rsp_err),
    .rsp_rdata(rsp_rdata),
    .cmd_n(cmd_n), .RDnWR(RDnWR), .Addr_in(Addr_in),
    .Data_in_vld(Data_in_vld), .Data_in(Data_in),
    .Data_out(Data_out), .data_out_vld(data_out_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;
  int rsp_count = 0;

  typedef struct {
    int          id;
    logic        rd;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } cmd_t;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  logic cmd_low_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_cmd(input int id, input logic rd, input logic [15:0] a,
                         input logic [31:0] d, input int c);
    cmd_t e;
    e.id = id; e.rd = rd; e.addr = a; e.wdata = d; e.cyc = c;
    cmd_q.push_back(e);
  endtask

  task automatic exp_rsp(input int id, input logic err, input logic [31:0] rdata, input int c);
    rsp_t e;
    e.id = id; e.err = err; e.rdata = rdata; e.cyc = c;
    rsp_q.push_back(e);
  endtask

  task automatic set_req(input int id, input logic rd, input logic [15:0] a, input logic [31:0] d);
    if (id == 0) begin
      r0_req_rdnwr = rd; r0_req_addr = a; r0_req_wdata = d; r0_req_vld = 1'b1;
    end else begin
      r1_req_rdnwr = rd; r1_req_addr = a; r1_req_wdata = d; r1_req_vld = 1'b1;
    end
  endtask

  task automatic drive_req(input int id, input logic rd, input logic [15:0] a,
                           input logic [31:0] d, input int issue_cyc);
    exp_cmd(id, rd, a, d, issue_cyc);
    set_req(id, rd, a, d);
  endtask

  task automatic wait_ack(input int id, input bit drop);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      tick();
      n++;
      got = (id == 0) ? r0_req_ack : r1_req_ack;
    end
    chk($sformatf("ack%0d_seen", id), 32'(got), 32'd1);
    if (drop || !got) begin
      if (id == 0) r0_req_vld = 1'b0;
      else         r1_req_vld = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_n"},     32'(cmd_n),                    32'd1);
    chk({tag, "_rdnwr"},     32'(RDnWR),                    32'd1);
    chk({tag, "_addr"},      32'(Addr_in),                  32'd0);
    chk({tag, "_data_in"},   Data_in,                       32'd0);
    chk({tag, "_din_vld"},   32'(Data_in_vld),              32'd0);
    chk({tag, "_acks"},      32'({r1_req_ack, r0_req_ack}), 32'd0);
    chk({tag, "_rsp_vld"},   32'({r1_rsp_vld, r0_rsp_vld}), 32'd0);
    chk({tag, "_rsp_err"},   32'({r1_rsp_err, r0_rsp_err}), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata,                     32'd0);
  endtask

  // Command-port monitor
  always @(negedge clk) begin : cmd_mon
    cmd_t ec;
    if (!cmd_n) begin
      chk("cmd_n_prev_low", 32'(cmd_low_prev), 32'd0);
      chk("cmd_unexpected", 32'(cmd_q.size() == 0), 32'd0);
      if (cmd_q.size() != 0) begin
        ec = cmd_q.pop_front();
        chk("cmd_ack",     32'({r1_req_ack, r0_req_ack}), (ec.id == 1) ? 32'd2 : 32'd1);
        chk("cmd_cyc",     cyc,                           ec.cyc);
        chk("cmd_rdnwr",   32'(RDnWR),                    32'(ec.rd));
        chk("cmd_addr",    32'(Addr_in),                  32'(ec.addr));
        chk("cmd_din_vld", 32'(Data_in_vld),              32'(!ec.rd));
        if (!ec.rd) chk("cmd_data", Data_in, ec.wdata);
      end
    end else if (r0_req_ack || r1_req_ack || Data_in_vld) begin
      chk("strobe_without_cmd", 32'({Data_in_vld, r1_req_ack, r0_req_ack}), 32'd0);
    end
    cmd_low_prev = !cmd_n;
  end

  // Response monitor
  always @(negedge clk) begin : rsp_mon
    rsp_t er;
    if (r0_rsp_vld || r1_rsp_vld) begin
      rsp_count++;
      chk("rsp_unexpected", 32'(rsp_q.size() == 0), 32'd0);
      if (rsp_q.size() != 0) begin
        er = rsp_q.pop_front();
        chk("rsp_vld",   32'({r1_rsp_vld, r0_rsp_vld}), (er.id == 1) ? 32'd2 : 32'd1);
        chk("rsp_err",   32'({r1_rsp_err, r0_rsp_err}),
            er.err ? ((er.id == 1) ? 32'd2 : 32'd1) : 32'd0);
        chk("rsp_rdata", rsp_rdata, er.rdata);
        chk("rsp_cyc",   cyc,       er.cyc);
      end
    end else if (r0_rsp_err || r1_rsp_err) begin
      chk("err_without_vld", 32'({r1_rsp_err, r0_rsp_err}), 32'd0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "bench time limit expired");
  end

  initial begin : stim
    int c;
    int n0;
    rst = 1'b1;
    r0_req_vld = 1'b0; r0_req_rdnwr = 1'b0; r0_req_addr = '0; r0_req_wdata = '0;
    r1_req_vld = 1'b0; r1_req_rdnwr = 1'b0; r1_req_addr = '0; r1_req_wdata = '0;
    Data_out = '0; data_out_vld = 1'b0;
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;

    // Contention from reset: both keep requesting, grants alternate r0, r1, r0, r1
    c = cyc;
    set_req(0, 1'b0, 16'h0A00, 32'hAAAA_0001);
    set_req(1, 1'b0, 16'h0B00, 32'hBBBB_0001);
    for (int k = 0; k < 4; k++) begin
      exp_cmd(k % 2, 1'b0, (k % 2 == 1) ? 16'h0B00 : 16'h0A00,
              (k % 2 == 1) ? 32'hBBBB_0001 : 32'hAAAA_0001, c + 1 + 6 * k);
      exp_rsp(k % 2, 1'b0, 32'h0, c + 6 + 6 * k);
    end
    for (int k = 0; k < 4; k++) wait_ack(k % 2, k >= 2);
    repeat (8) tick();

    // Single read, data three cycles after ISSUE
    c = cyc;
    drive_req(0, 1'b1, 16'h0012, 32'h0, c + 1);
    exp_rsp(0, 1'b0, 32'hA5A5_0001, c + 5);
    wait_ack(0, 1'b1);
    repeat (3) tick();
    data_out_vld = 1'b1; Data_out = 32'hA5A5_0001;
    tick();
    data_out_vld = 1'b0; Data_out = '0;
    repeat (3) tick();

    // Single write from r1; read data register keeps the last read value
    c = cyc;
    drive_req(1, 1'b0, 16'h0100, 32'hDEAD_BEEF, c + 1);
    exp_rsp(1, 1'b0, 32'hA5A5_0001, c + 6);
    wait_ack(1, 1'b1);
    repeat (7) tick();

    // Stray read data while idle
    n0 = rsp_count;
    data_out_vld = 1'b1; Data_out = 32'hFFFF_0000;
    tick();
    data_out_vld = 1'b0; Data_out = '0;
    repeat (4) tick();
    chk("stray_rsp_count", rsp_count, n0);
    chk("stray_rdata",     rsp_rdata, 32'hA5A5_0001);
    chk("stray_cmd_n",     32'(cmd_n), 32'd1);

    // Read timeout on r0, then a pending r1 write is served
    c = cyc;
    drive_req(0, 1'b1, 16'h0040, 32'h0, c + 1);
    exp_rsp(0, 1'b1, 32'h0, c + 66);
    wait_ack(0, 1'b1);
    drive_req(1, 1'b0, 16'h0200, 32'h1234_5678, c + 67);
    exp_rsp(1, 1'b0, 32'h0, c + 72);
    wait_ack(1, 1'b1);
    repeat (7) tick();

    // Data arrives on the timeout cycle: data wins, no error
    c = cyc;
    drive_req(0, 1'b1, 16'h0077, 32'h0, c + 1);
    exp_rsp(0, 1'b0, 32'h0BAD_F00D, c + 66);
    wait_ack(0, 1'b1);
    repeat (64) tick();
    data_out_vld = 1'b1; Data_out = 32'h0BAD_F00D;
    tick();
    data_out_vld = 1'b0; Data_out = '0;
    repeat (3) tick();

    // Reset during WAIT_RD aborts the read; late data is ignored
    c = cyc;
    drive_req(1, 1'b1, 16'h0033, 32'h0, c + 1);
    wait_ack(1, 1'b1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    n0 = rsp_count;
    data_out_vld = 1'b1; Data_out = 32'h5555_AAAA;
    tick();
    data_out_vld = 1'b0; Data_out = '0;
    repeat (4) tick();
    chk("late_rsp_count", rsp_count, n0);
    chk("late_rdata",     rsp_rdata, 32'h0);

    chk("cmd_q_left", cmd_q.size(), 32'd0);
    chk("rsp_q_left", rsp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
